// File: rtl/button_event_classifier.sv
// button_event_classifier
// Classifies gestures on a clean, debounced button level into short, long and
// double presses. Each classification is a registered single-cycle pulse;
// `held` and `busy` are registered levels derived from the next state.

module button_event_classifier #(
  parameter int CNT_W = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             debounced,
  input  logic [CNT_W-1:0] long_value,
  input  logic [CNT_W-1:0] gap_value,
  output logic             short_press,
  output logic             long_press,
  output logic             double_press,
  output logic             held,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    LONG   = 3'd2,
    WAIT2  = 3'd3,
    PRESS2 = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Last count value of a long hold; a threshold of 0 behaves like 1.
  function automatic logic [CNT_W-1:0] long_limit(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_ONE;
  endfunction

  // Last count value of the release gap. A zero gap never reaches WAIT2 from
  // PRESS1; if it is changed to 0 mid-gap the wrapped limit equals the
  // saturation value, which exits WAIT2 anyway.
  function automatic logic [CNT_W-1:0] gap_limit(input logic [CNT_W-1:0] v);
    return v - CNT_ONE;
  endfunction

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             prev;
  logic             short_n, long_n, double_n;
  logic             rise, fall;

  assign rise = debounced & ~prev;
  assign fall = ~debounced & prev;

  // State, counter, edge-history and output registers. `prev` resets high so
  // a button already down when reset releases must be let go before it counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      prev         <= 1'b1;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      held         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      prev         <= debounced;
      short_press  <= short_n;
      long_press   <= long_n;
      double_press <= double_n;
      held         <= (state_n == LONG);
      busy         <= (state_n != IDLE);
    end
  end

  // Next-state, counter and pulse decode. Edge events take priority over
  // threshold matches in every state.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    short_n  = 1'b0;
    long_n   = 1'b0;
    double_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (rise) begin
          state_n = PRESS1;
          cnt_n   = '0;
        end
      end

      PRESS1: begin
        if (fall) begin
          cnt_n = '0;
          if (gap_value == '0) begin
            state_n = IDLE;
            short_n = 1'b1;
          end else begin
            state_n = WAIT2;
          end
        end else if (debounced && (cnt == long_limit(long_value))) begin
          state_n = LONG;
          long_n  = 1'b1;
        end else begin
          cnt_n = sat_inc(cnt);
        end
      end

      LONG: begin
        if (fall) begin
          state_n = IDLE;
        end
      end

      WAIT2: begin
        if (rise) begin
          state_n = PRESS2;
        end else if ((cnt == gap_limit(gap_value)) || (cnt == CNT_MAX)) begin
          state_n = IDLE;
          short_n = 1'b1;
        end else begin
          cnt_n = sat_inc(cnt);
        end
      end

      PRESS2: begin
        if (fall) begin
          state_n  = IDLE;
          double_n = 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_event_classifier.sv
// Scoreboard bench for button_event_classifier. Stimulus pushes the edge number
// at which each pulse is expected; a monitor pops and compares whenever a pulse
// appears. Hold lengths count edges after the accepting rise edge E0, so
// hold=n keeps the button high through E0+n and the fall is accepted at E0+n+1.

module tb_button_event_classifier;

  localparam int CNT_W = 18;
  localparam int K_SHORT  = 0;
  localparam int K_LONG   = 1;
  localparam int K_DOUBLE = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             debounced;
  logic [CNT_W-1:0] long_value;
  logic [CNT_W-1:0] gap_value;
  logic             short_press;
  logic             long_press;
  logic             double_press;
  logic             held;
  logic             busy;

  typedef struct {
    int kind;
    int edge_at;
  } exp_t;

  exp_t exp_q[$];
  int   edge_no = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   last_e0 = 0;
  int   last_f0 = 0;

  button_event_classifier #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .debounced    (debounced),
    .long_value   (long_value),
    .gap_value    (gap_value),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_press (double_press),
    .held         (held),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic string kname(input int k);
    if (k == K_SHORT) return "short";
    if (k == K_LONG)  return "long";
    return "double";
  endfunction

  task automatic expect_pulse(input int kind, input int at);
    exp_q.push_back('{kind, at});
  endtask

  task automatic check_level(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0b, required %0b", name, edge_no, act, req);
    end
  endtask

  task automatic check_all_zero(input string name);
    check_level({name, "_short"},  short_press,  1'b0);
    check_level({name, "_long"},   long_press,   1'b0);
    check_level({name, "_double"}, double_press, 1'b0);
    check_level({name, "_held"},   held,         1'b0);
    check_level({name, "_busy"},   busy,         1'b0);
  endtask

  // Press, hold through E0+hold, then release (called at a negedge).
  task automatic drive_high(input int hold);
    debounced = 1'b1;
    last_e0   = edge_no + 1;
    repeat (hold + 1) @(negedge clk);
    debounced = 1'b0;
    last_f0   = edge_no + 1;
  endtask

  // Keep released; a following drive_high rises at last_f0 + g.
  task automatic wait_low(input int g);
    repeat (g) @(negedge clk);
  endtask

  task automatic idle(input int n);
    debounced = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    int   k;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      edge_no++;
      if (short_press || long_press || double_press) begin
        k = short_press ? K_SHORT : (long_press ? K_LONG : K_DOUBLE);
        checks++;
        if ($countones({short_press, long_press, double_press}) > 1) begin
          errors++;
          $display("FAIL onehot at edge %0d: got %b, required at most one pulse",
                   edge_no, {short_press, long_press, double_press});
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse at edge %0d: got %s, required none",
                   edge_no, kname(k));
        end else begin
          e = exp_q.pop_front();
          if (e.kind != k || e.edge_at != edge_no) begin
            errors++;
            $display("FAIL pulse: got %s at edge %0d, required %s at edge %0d",
                     kname(k), edge_no, kname(e.kind), e.edge_at);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int f1;
    reset      = 1'b1;
    debounced  = 1'b1;
    long_value = CNT_W'(50);
    gap_value  = CNT_W'(10);

    // Held through reset: no press, then normal classification.
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check_level("held_thru_reset_busy", busy, 1'b0);
    idle(5);
    drive_high(8);
    expect_pulse(K_SHORT, last_f0 + 10);
    idle(15);
    check_level("after_reset_short_busy", busy, 1'b0);

    // Short press with busy tracking.
    drive_high(8);
    expect_pulse(K_SHORT, last_f0 + 10);
    check_level("short_busy_press1", busy, 1'b1);
    wait_low(10);
    check_level("short_busy_wait2", busy, 1'b1);
    @(negedge clk);
    check_level("short_busy_done", busy, 1'b0);
    idle(10);

    // Long press: hold 80 edges.
    debounced = 1'b1;
    last_e0 = edge_no + 1;
    expect_pulse(K_LONG, last_e0 + 50);
    repeat (50) @(negedge clk);
    check_level("long_held_before", held, 1'b0);
    @(negedge clk);
    check_level("long_held_at", held, 1'b1);
    check_level("long_busy_at", busy, 1'b1);
    repeat (29) @(negedge clk);
    check_level("long_held_late", held, 1'b1);
    debounced = 1'b0;
    @(negedge clk);
    check_level("long_held_release", held, 1'b0);
    check_level("long_busy_release", busy, 1'b0);
    idle(15);

    // Double press: press 3, release 4, press 3.
    drive_high(3);
    wait_low(4);
    drive_high(3);
    expect_pulse(K_DOUBLE, last_f0);
    idle(15);

    // Boundary: 49 -> short, 50 -> long.
    drive_high(49);
    expect_pulse(K_SHORT, last_f0 + 10);
    idle(15);
    debounced = 1'b1;
    expect_pulse(K_LONG, edge_no + 1 + 50);
    repeat (51) @(negedge clk);
    debounced = 1'b0;
    idle(15);

    // Repress on the expiry edge -> double.
    drive_high(3);
    wait_low(10);
    drive_high(3);
    expect_pulse(K_DOUBLE, last_f0);
    idle(15);

    // Repress one edge late -> short, then a fresh PRESS1.
    drive_high(3);
    f1 = last_f0;
    expect_pulse(K_SHORT, f1 + 10);
    wait_low(11);
    drive_high(3);
    check_level("late_repress_busy", busy, 1'b1);
    expect_pulse(K_SHORT, last_f0 + 10);
    idle(15);

    // Reset during WAIT2.
    drive_high(3);
    wait_low(3);
    reset = 1'b1;
    #1;
    check_all_zero("reset_wait2");
    @(negedge clk);
    reset = 1'b0;
    idle(15);

    // Reset during PRESS2.
    drive_high(3);
    wait_low(3);
    debounced = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_all_zero("reset_press2");
    @(negedge clk);
    debounced = 1'b0;
    reset = 1'b0;
    idle(15);

    // Zero gap: short right after the fall edge.
    gap_value = '0;
    drive_high(5);
    expect_pulse(K_SHORT, last_f0);
    idle(5);
    check_level("gap0_busy", busy, 1'b0);
    gap_value = CNT_W'(10);

    // Zero long threshold behaves like 1.
    long_value = '0;
    idle(2);
    debounced = 1'b1;
    expect_pulse(K_LONG, edge_no + 1 + 1);
    repeat (4) @(negedge clk);
    debounced = 1'b0;
    idle(10);
    long_value = CNT_W'(50);

    idle(20);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_pulses: got %0d outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_event_classifier.md
# button_event_classifier

Downstream consumer of the delayed button debouncer. Takes the clean `debounced` level and classifies each user gesture as a short press, long press or double press. Each classification is a single-cycle pulse to the control logic. Thresholds are runtime inputs with the same 18-bit width as the debouncer's `Final_value`, so both stages are configured the same way.

## Interface
- `CNT_W`, default 18: width of the cycle counter and of both threshold inputs.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high. Forces every register to its reset value immediately.
- `debounced`  in  1  clean button level from the debouncer, synchronous to `clk`.
- `long_value`  in  CNT_W  hold time, in cycles, that qualifies a long press. 0 is treated as 1.
- `gap_value`  in  CNT_W  maximum release-to-repress gap, in cycles, for a double press.
- `short_press`  out  1  one-cycle pulse: single press, released before `long_value`, no second press within `gap_value`.
- `long_press`  out  1  one-cycle pulse: button held for `long_value` cycles.
- `double_press`  out  1  one-cycle pulse: second press released after a qualifying gap.
- `held`  out  1  level: high while in state LONG.
- `busy`  out  1  level: high whenever state is not IDLE.

## Operation
- Edge detection uses a registered copy `prev` of `debounced`.
  - rise = `debounced & ~prev`
  - fall = `~debounced & prev`
- `prev` resets to 1. A button already held when reset is released is not a press; it must be released first.
- Counter `cnt` is CNT_W bits wide, unsigned. It saturates at all-ones and never wraps.
- All outputs are registered. Reset value is 0 for every output. State resets to IDLE and `cnt` to 0.
- States and transitions, evaluated at each edge:
  - IDLE:
    - rise: go to PRESS1, `cnt`<=0.
  - PRESS1:
    - fall: go to WAIT2, `cnt`<=0. If `gap_value`==0, instead go to IDLE and pulse `short_press`.
    - else if `debounced`=1 and `cnt`==`long_value`-1: go to LONG and pulse `long_press`.
    - else: `cnt`++.
  - LONG:
    - fall: go to IDLE. No further pulse is emitted.
  - WAIT2:
    - rise: go to PRESS2.
    - else if `cnt`==`gap_value`-1: go to IDLE and pulse `short_press`.
    - else: `cnt`++.
  - PRESS2:
    - fall: go to IDLE and pulse `double_press`.
    - Holding in PRESS2 never produces `long_press`.
- Simultaneous events:
  - In PRESS1, fall beats the long threshold.
  - In WAIT2, rise beats gap expiry, so a repress on the expiry cycle is a double press.
- At most one of `short_press`, `long_press`, `double_press` is high in any cycle.
- Threshold inputs are sampled every cycle. Changing them mid-gesture takes effect at the next comparison. If the new threshold is already passed by `cnt`, the comparison never matches: PRESS1 then waits for fall, and WAIT2 waits for rise or saturation.
  - Implementation requirement: WAIT2 also exits to IDLE with `short_press` when `cnt` saturates.
- Reset asserted mid-gesture aborts it silently: no pulse is emitted, state goes to IDLE and `prev` goes to 1.

## Timing
- Rise accepted at edge E0, i.e. the first edge with `debounced`=1 and `prev`=0.
- `long_press` is high for exactly one cycle after edge E0+`long_value`, provided `debounced` stays high through that edge.
- Fall accepted at edge F0. `short_press` is high for one cycle after edge F0+`gap_value` if no rise occurred.
  - With `gap_value`=0, `short_press` is high after F0 itself.
- `double_press` is high for one cycle after the edge that accepts the second fall.
- `held` rises with `long_press` and falls after the edge accepting the release.
- `busy` rises after E0 and falls on the same edge as the terminating pulse.
- Minimum input-to-output latency: 1 cycle.

## Test plan
All scenarios use `long_value`=50, `gap_value`=10, and hold `debounced` for whole clocks.
- Reset while `debounced`=1, then release reset and hold 100 cycles → no pulse, `busy`=0. After a 5-cycle release and repress, normal classification resumes.
- Press for 8 cycles, then release → `short_press` pulse exactly 10 cycles after the fall edge. No other pulse. `busy` low the following cycle.
- Press and hold 80 cycles → `long_press` 50 cycles after E0, `held`=1 from then until release. No `short_press` on release.
- Press 3, release 4, press 3, release → single `double_press` after the second fall. No `short_press`.
- Boundaries:
  - Press for exactly 49 cycles → short.
  - Press for exactly 50 cycles → long.
  - Repress on gap cycle 10 (the expiry edge) → double.
  - Repress on gap cycle 11 → short followed by a new PRESS1.
- Assert reset in WAIT2 and in PRESS2 → no pulse, all outputs 0 immediately. Also run with `gap_value`=0 → `short_press` one cycle after the fall.
